blinkt_wb_arbiter: RTL

//  2-master -> 1-slave Wishbone classic arbiter in front of the blinktLEDBar register slave.

---
 rtl/blinkt_wb_pkg.sv | 27 ++
 rtl/blinkt_wb_watchdog.sv | 39 +++
 rtl/blinkt_wb_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/blinkt_wb_pkg.sv
// Shared types and defaults for the blinktLEDBar Wishbone arbiter.
package blinkt_wb_pkg;

  // Bus geometry shared with the blinktLEDBar register slave.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  // Arbiter states: no owner, m0 owns, m1 owns, watchdog-aborted tenure.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // Master identifier: 0 = serial bridge (m0), 1 = pattern engine (m1).
  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  // One-hot grant vector for a master id (bit0 = m0, bit1 = m1).
  function automatic logic [1:0] grant_onehot(input master_id_t id);
    return (id == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/blinkt_wb_watchdog.sv
// Watchdog for unanswered strobes. Counts cycles with run high; clr wins.
// expired is high for the single cycle in which the count equals TIMEOUT,
// after which the counter restarts from zero.
module blinkt_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT));

  // Next count: clear on request or after firing, otherwise advance while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blinkt_wb_arbiter.sv
// 2-master -> 1-slave Wishbone classic arbiter for the blinktLEDBar slave.
// m0 = serial bridge, m1 = pattern engine. Round-robin per tenure, grant held
// for the whole CYC, at least one IDLE cycle between tenures.
// Optional hung-slave watchdog enabled by defining BLINKT_WB_ARB_TIMEOUT_EN;
// the port list is the same either way.
module blinkt_wb_arbiter
  import blinkt_wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  // master 0
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  input  logic                    m0_wb_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_wb_sel_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_cyc_i,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_err_o,
  output logic                    m0_wb_rty_o,
  // master 1
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  input  logic                    m1_wb_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_wb_sel_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_cyc_i,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_err_o,
  output logic                    m1_wb_rty_o,
  // slave
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic                    s_wb_we_o,
  output logic [SELECT_WIDTH-1:0] s_wb_sel_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  input  logic                    s_wb_ack_i,
  input  logic                    s_wb_err_i,
  input  logic                    s_wb_rty_i,
  // status
  output logic [1:0]              o_grant
);

  arb_state_t state_q, state_d;
  master_id_t last_owner_q, last_owner_d;

  // Owner's request signals, selected by the registered owner id.
  logic [ADDR_WIDTH-1:0]   own_adr;
  logic [DATA_WIDTH-1:0]   own_dat;
  logic                    own_we;
  logic [SELECT_WIDTH-1:0] own_sel;
  logic                    own_stb;
  logic                    own_cyc;

  logic in_own;      // OWN0 or OWN1: slave access may be in progress
  logic granted;     // any state but IDLE: an owner exists
  logic drive;       // owner is actually connected to the slave this cycle
  logic s_resp;      // any slave response
  logic wd_expired;  // watchdog fires this cycle (always 0 without the watchdog)

  // last_owner_q doubles as the current owner while a tenure is active,
  // since it is updated at the moment of grant.
  always_comb begin
    if (last_owner_q == M1) begin
      own_adr = m1_wb_adr_i;
      own_dat = m1_wb_dat_i;
      own_we  = m1_wb_we_i;
      own_sel = m1_wb_sel_i;
      own_stb = m1_wb_stb_i;
      own_cyc = m1_wb_cyc_i;
    end else begin
      own_adr = m0_wb_adr_i;
      own_dat = m0_wb_dat_i;
      own_we  = m0_wb_we_i;
      own_sel = m0_wb_sel_i;
      own_stb = m0_wb_stb_i;
      own_cyc = m0_wb_cyc_i;
    end
  end

  assign in_own  = (state_q == OWN0) || (state_q == OWN1);
  assign granted = (state_q != IDLE);
  assign s_resp  = s_wb_ack_i | s_wb_err_i | s_wb_rty_i;

`ifdef BLINKT_WB_ARB_TIMEOUT_EN
  logic wd_run;
  logic wd_clr;

  // Count only while the owner strobes an active tenure with no answer.
  assign wd_run = in_own & own_stb;
  assign wd_clr = ~wd_run | s_resp;

  blinkt_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (wd_clr),
    .run     (wd_run),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;

  // Without the watchdog a hung slave simply holds the bus.
  assign wd_expired     = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Next-state and round-robin arbitration. A tie goes to the master that
  // did not own the previous tenure; a lone requester always wins.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          last_owner_d = ~last_owner_q;
          state_d      = (last_owner_q == M1) ? OWN0 : OWN1;
        end else if (m0_wb_cyc_i) begin
          last_owner_d = M0;
          state_d      = OWN0;
        end else if (m1_wb_cyc_i) begin
          last_owner_d = M1;
          state_d      = OWN1;
        end
      end
      OWN0, OWN1: begin
        // Release wins over a coincident expiry: the owner is already gone.
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (wd_expired) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin history registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= M1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Slave-side mux. Everything is zero with no owner; cyc/stb are also cut
  // in ABORT and in the expiry cycle itself so the slave sees the access end.
  assign drive = in_own & ~wd_expired;

  always_comb begin
    s_wb_adr_o = granted ? own_adr : '0;
    s_wb_dat_o = granted ? own_dat : '0;
    s_wb_we_o  = granted & own_we;
    s_wb_sel_o = granted ? own_sel : '0;
    s_wb_cyc_o = drive & own_cyc;
    s_wb_stb_o = drive & own_stb;
  end

  // Response routing: only the owner sees slave responses, and only while
  // connected; responses during ABORT are dropped. Expiry adds an err pulse.
  always_comb begin
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m0_wb_rty_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    m1_wb_rty_o = 1'b0;
    if (last_owner_q == M1) begin
      m1_wb_ack_o = drive & s_wb_ack_i;
      m1_wb_err_o = (drive & s_wb_err_i) | (in_own & wd_expired);
      m1_wb_rty_o = drive & s_wb_rty_i;
    end else begin
      m0_wb_ack_o = drive & s_wb_ack_i;
      m0_wb_err_o = (drive & s_wb_err_i) | (in_own & wd_expired);
      m0_wb_rty_o = drive & s_wb_rty_i;
    end
  end

  // Read data is broadcast; masters qualify it with their own ack.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  assign o_grant = granted ? grant_onehot(last_owner_q) : 2'b00;

endmodule
